// File: rtl/mp_pkg.sv
// mp_pkg: shared types, requester ids and sizing helper for the memory bus arbiter
package mp_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LDST  = 1;
    localparam int REQ_IO    = 2;

    // Bits needed to index n items, never less than one.
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner select
//   req  - pending requests
//   last - index of the previous winner; search starts at last+1 and wraps
//   win  - one-hot winner, zero when nothing is requested
module rr_pick
    import mp_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int LW    = idx_w(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [LW-1:0]    last,
    output logic [N_REQ-1:0] win
);

    logic [LW-1:0]    start;
    logic [N_REQ-1:0] rot;
    logic [N_REQ-1:0] first;

    // Rotate so the search origin sits at bit 0, isolate the lowest set bit,
    // then rotate back; the doubled vector turns each rotate into a plain shift.
    always_comb begin
        start = (last == LW'(N_REQ - 1)) ? '0 : last + LW'(1);
        rot   = N_REQ'({req, req} >> start);
        first = rot & (~rot + N_REQ'(1));
        win   = N_REQ'(({first, first} << start) >> N_REQ);
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sequencing requesters onto one memory port
//   clk, init_n            - clock, asynchronous active-low reset
//   req/we/addr/wdata      - per-requester request, write enable, packed address/data
//   hold                   - blocks new grants while high
//   gnt/ack/rdata/busy     - one-hot grant, one-cycle completion pulse, read data, busy
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - memory port
module mem_bus_arbiter
    import mp_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
)(
    input  logic                    clk,
    input  logic                    init_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        we,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    input  logic [N_REQ*DATA_W-1:0] wdata,
    input  logic                    hold,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        ack,
    output logic [DATA_W-1:0]       rdata,
    output logic                    busy,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [DATA_W-1:0]       mem_rdata
);

    localparam int LW = idx_w(N_REQ);
    localparam int CW = idx_w(WAIT_CYCLES + 1);

    arb_state_t        state_q, state_d;
    logic [LW-1:0]     last_q, last_d, win_idx;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]  win, gnt_q, gnt_d, ack_q, ack_d;
    logic [DATA_W-1:0] rdata_q, rdata_d, mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              busy_q, busy_d, mem_en_q, mem_en_d, mem_we_q, mem_we_d;

    rr_pick #(.N_REQ(N_REQ), .LW(LW)) u_pick (
        .req  (req),
        .last (last_q),
        .win  (win)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (win[i]) win_idx = LW'(i);
        state_d     = state_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (|win && !hold) begin
                state_d     = ACCESS;
                last_d      = win_idx;
                cnt_d       = CW'(WAIT_CYCLES);
                gnt_d       = win;
                busy_d      = 1'b1;
                mem_en_d    = 1'b1;
                mem_we_d    = we[win_idx];
                mem_addr_d  = addr[int'(win_idx)*ADDR_W +: ADDR_W];
                mem_wdata_d = wdata[int'(win_idx)*DATA_W +: DATA_W];
            end
            ACCESS: if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d  = DONE;
                ack_d    = gnt_q;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                rdata_d  = mem_we_q ? rdata_q : mem_rdata;
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= IDLE;
            last_q      <= LW'(N_REQ - 1);
            cnt_q       <= '0;
            gnt_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed scoreboard bench for the memory bus arbiter
module tb_mem_bus_arbiter;
    import mp_pkg::*;

    localparam int N  = 3;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int WC = 1;

    logic            clk = 1'b0;
    logic            init_n = 1'b1;
    logic            hold = 1'b0;
    logic [N-1:0]    req = '0, we = '0, gnt, ack;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata = '0;
    logic [AW-1:0]   mem_addr;
    logic            busy, mem_en, mem_we;

    int checks = 0, passed = 0, fails = 0;

    typedef struct {
        int          id;
        logic        w;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [DW-1:0] mem;
        logic [DW-1:0] rd;
    } txn_t;

    txn_t          sb[$];
    logic [DW-1:0] model_rdata = '0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut (
        .clk       (clk),
        .init_n    (init_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .hold      (hold),
        .gnt       (gnt),
        .ack       (ack),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    always @(negedge clk) if (init_n) begin
        chk("gnt_onehot", 64'($onehot0(gnt)), 64'd1);
        chk("ack_onehot", 64'($onehot0(ack)), 64'd1);
    end

    task automatic drive(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        req[id]             = 1'b1;
        we[id]              = w;
        addr[id*AW +: AW]   = a;
        wdata[id*DW +: DW]  = wd;
    endtask

    // Reads update the expected shared rdata; writes must leave it alone.
    task automatic push(input int id, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [DW-1:0] mem);
        txn_t t;
        if (!w) model_rdata = mem;
        t.id  = id;
        t.w   = w;
        t.a   = a;
        t.wd  = wd;
        t.mem = mem;
        t.rd  = model_rdata;
        sb.push_back(t);
    endtask

    task automatic collect(input bit drop, input int exp_lat);
        txn_t t;
        int   lat = 0;
        t = sb.pop_front();
        do begin
            tick();
            lat++;
        end while (gnt == '0 && lat < 20);
        chk("grant_latency", 64'(lat), 64'(exp_lat));
        if (gnt == '0) return;
        chk("gnt", 64'(gnt), 64'(1) << t.id);
        chk("busy_grant", 64'(busy), 64'd1);
        chk("mem_en_grant", 64'(mem_en), 64'd1);
        chk("mem_we_grant", 64'(mem_we), 64'(t.w));
        chk("mem_addr_grant", 64'(mem_addr), 64'(t.a));
        chk("mem_wdata_grant", 64'(mem_wdata), 64'(t.wd));
        chk("ack_grant", 64'(ack), 64'd0);
        if (drop) begin
            req[t.id]              = 1'b0;
            we[t.id]               = ~we[t.id];
            addr[t.id*AW +: AW]    = ~addr[t.id*AW +: AW];
            wdata[t.id*DW +: DW]   = ~wdata[t.id*DW +: DW];
        end
        mem_rdata = t.mem;
        repeat (WC) begin
            tick();
            chk("mem_en_wait", 64'(mem_en), 64'd1);
            chk("mem_we_wait", 64'(mem_we), 64'(t.w));
            chk("mem_addr_wait", 64'(mem_addr), 64'(t.a));
            chk("mem_wdata_wait", 64'(mem_wdata), 64'(t.wd));
            chk("ack_wait", 64'(ack), 64'd0);
        end
        tick();
        chk("ack", 64'(ack), 64'(1) << t.id);
        chk("gnt_done", 64'(gnt), 64'(1) << t.id);
        chk("mem_en_done", 64'(mem_en), 64'd0);
        chk("mem_we_done", 64'(mem_we), 64'd0);
        chk("rdata", 64'(rdata), 64'(t.rd));
        tick();
        chk("busy_idle", 64'(busy), 64'd0);
        chk("gnt_idle", 64'(gnt), 64'd0);
        chk("ack_idle", 64'(ack), 64'd0);
        chk("mem_addr_keep", 64'(mem_addr), 64'(t.a));
    endtask

    initial begin
        #1 init_n = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        init_n = 1'b1;

        drive(REQ_FETCH, 1'b0, 16'h0040, 16'h0000);
        push(REQ_FETCH, 1'b0, 16'h0040, 16'h0000, 16'hBEEF);
        collect(1'b1, 1);

        drive(REQ_LDST, 1'b1, 16'h0100, 16'h1234);
        push(REQ_LDST, 1'b1, 16'h0100, 16'h1234, 16'h5555);
        collect(1'b1, 1);

        init_n = 1'b0;
        model_rdata = '0;
        drive(REQ_FETCH, 1'b0, 16'h0040, 16'h0000);
        drive(REQ_LDST, 1'b0, 16'h0100, 16'h0000);
        drive(REQ_IO, 1'b0, 16'h0200, 16'h0000);
        tick();
        init_n = 1'b1;
        push(REQ_FETCH, 1'b0, 16'h0040, 16'h0000, 16'h1111);
        push(REQ_LDST, 1'b0, 16'h0100, 16'h0000, 16'h2222);
        push(REQ_IO, 1'b0, 16'h0200, 16'h0000, 16'h3333);
        push(REQ_FETCH, 1'b0, 16'h0040, 16'h0000, 16'h4444);
        repeat (4) collect(1'b0, 1);
        req = '0;

        hold = 1'b1;
        drive(REQ_IO, 1'b0, 16'h0200, 16'h0000);
        repeat (10) begin
            tick();
            chk("hold_gnt", 64'(gnt), 64'd0);
            chk("hold_busy", 64'(busy), 64'd0);
        end
        hold = 1'b0;
        push(REQ_IO, 1'b0, 16'h0200, 16'h0000, 16'hC0DE);
        collect(1'b1, 1);

        drive(REQ_FETCH, 1'b0, 16'h0044, 16'h0000);
        push(REQ_FETCH, 1'b0, 16'h0044, 16'h0000, 16'h7777);
        collect(1'b1, 1);

        drive(REQ_LDST, 1'b0, 16'h0100, 16'h0000);
        tick();
        chk("mid_gnt", 64'(gnt), 64'b010);
        chk("mid_busy", 64'(busy), 64'd1);
        #1 init_n = 1'b0;
        model_rdata = '0;
        #1;
        chk("async_gnt", 64'(gnt), 64'd0);
        chk("async_mem_en", 64'(mem_en), 64'd0);
        chk("async_busy", 64'(busy), 64'd0);
        chk("async_rdata", 64'(rdata), 64'd0);
        tick();
        tick();
        chk("async_ack", 64'(ack), 64'd0);
        req = '0;
        drive(REQ_FETCH, 1'b0, 16'h0048, 16'h0000);
        drive(REQ_LDST, 1'b0, 16'h0104, 16'h0000);
        init_n = 1'b1;
        push(REQ_FETCH, 1'b0, 16'h0048, 16'h0000, 16'hA5A5);
        push(REQ_LDST, 1'b0, 16'h0104, 16'h0000, 16'h5A5A);
        collect(1'b1, 1);
        collect(1'b1, 1);

        req = '0;
        tick();
        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
